// File: rtl/md_if.sv
// Request/result bundle between the EXE-stage control and the multiply/divide unit.
// start is a one-cycle request qualified only when busy is low; busy/hi/lo are registered.
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo, dbg_state
  );
endinterface

// File: rtl/md_unit.sv
// MIPS multiply/divide unit: multi-cycle mult/multu/div/divu with architectural HI/LO,
// plus mthi/mtlo. The result is computed at acceptance and committed after N busy cycles.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    pend_hi_q, pend_hi_d;
  logic [31:0]    pend_lo_q, pend_lo_d;
  logic           pend_wr_q, pend_wr_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  logic is_mul, is_div, is_mthi, is_mtlo;
  logic accept, md_accept, last_cycle;

  assign is_mul  = (md.op[2:1] == 2'b00);
  assign is_div  = (md.op[2:1] == 2'b01);
  assign is_mthi = (md.op == 3'b100);
  assign is_mtlo = (md.op == 3'b101);

  assign accept     = md.start && (state_q == S_IDLE);
  assign md_accept  = accept && (is_mul || is_div);
  assign last_cycle = (state_q == S_BUSY) && (cnt_q == CW'(1));

  // Arithmetic: op[0] selects the unsigned variant for both mult and div.
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    a_ext = md.op[0] ? {32'd0, md.a} : {{32{md.a[31]}}, md.a};
    b_ext = md.op[0] ? {32'd0, md.b} : {{32{md.b[31]}}, md.b};
    prod  = a_ext * b_ext;
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    a_neg = !md.op[0] && md.a[31];
    b_neg = !md.op[0] && md.b[31];
    a_mag = a_neg ? (32'd0 - md.a) : md.a;
    b_mag = b_neg ? (32'd0 - md.b) : md.b;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem  = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_accept)  state_d = S_BUSY;
      S_BUSY:  if (last_cycle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md_accept) begin
          cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          if (is_mul) begin
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
            pend_wr_d = 1'b1;
          end else begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_wr_d = (md.b != 32'd0);
          end
        end else if (accept && is_mthi) begin
          hi_d = md.a;
        end else if (accept && is_mtlo) begin
          lo_d = md.a;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (last_cycle && pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.busy      = (state_q == S_BUSY);
  assign md.dbg_state = state_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

endmodule
